// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode encoding, flag bit positions
// and the control FSM states.
package alu_pkg;

    typedef enum logic [4:0] {
        OP_ADD = 5'd0,
        OP_SUB = 5'd1,
        OP_AND = 5'd2,
        OP_OR  = 5'd3,
        OP_XOR = 5'd4,
        OP_CP  = 5'd5,
        OP_SLL = 5'd6,
        OP_SRL = 5'd7,
        OP_SLA = 5'd8,
        OP_SRA = 5'd9,
        OP_ROL = 5'd10,
        OP_ROR = 5'd11,
        OP_INC = 5'd12,
        OP_DEC = 5'd13,
        OP_ADC = 5'd14,
        OP_SBC = 5'd15
    } op_e;

    localparam int FLAG_S = 7;
    localparam int FLAG_Z = 6;
    localparam int FLAG_H = 4;
    localparam int FLAG_P = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_HOLD  = 2'd3
    } st_e;

    function automatic logic is_shift(input logic [4:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SLA) ||
               (op == OP_SRA) || (op == OP_ROL) || (op == OP_ROR);
    endfunction

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational flag generator for alu_seq; ADC/SBC handling is present only
// when ALU_CARRY_IN_EN is defined.
module alu_flag_gen
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] res,
    input  logic             carry,
    input  logic             c_prev,
    output logic [7:0]       flags
);

    localparam int HB  = (WIDTH == 16) ? 12 : 4;
    localparam int MSB = WIDTH - 1;

    logic h_w;
    logic v_add;
    logic v_sub;
    logic par_w;
    logic known;

    // Carry into bit HB equals the carry/borrow out of the nibble below it,
    // for both addition and subtraction.
    assign h_w   = a[HB] ^ b[HB] ^ res[HB];
    assign v_add = ~(a[MSB] ^ b[MSB]) & (res[MSB] ^ a[MSB]);
    assign v_sub =  (a[MSB] ^ b[MSB]) & (res[MSB] ^ a[MSB]);
    assign par_w = ~^res;

    always_comb begin
        flags = '0;
        known = 1'b1;
        case (op)
`ifdef ALU_CARRY_IN_EN
            OP_ADD, OP_ADC: begin
`else
            OP_ADD: begin
`endif
                flags[FLAG_H] = h_w;
                flags[FLAG_P] = v_add;
                flags[FLAG_C] = carry;
            end
`ifdef ALU_CARRY_IN_EN
            OP_SUB, OP_CP, OP_SBC: begin
`else
            OP_SUB, OP_CP: begin
`endif
                flags[FLAG_H] = h_w;
                flags[FLAG_P] = v_sub;
                flags[FLAG_N] = 1'b1;
                flags[FLAG_C] = carry;
            end
            OP_INC: begin
                flags[FLAG_H] = h_w;
                flags[FLAG_P] = v_add;
                flags[FLAG_C] = c_prev;
            end
            OP_DEC: begin
                flags[FLAG_H] = h_w;
                flags[FLAG_P] = v_sub;
                flags[FLAG_N] = 1'b1;
                flags[FLAG_C] = c_prev;
            end
            OP_AND: begin
                flags[FLAG_H] = 1'b1;
                flags[FLAG_P] = par_w;
            end
            OP_OR, OP_XOR: flags[FLAG_P] = par_w;
            OP_SLL, OP_SRL, OP_SLA, OP_SRA, OP_ROL, OP_ROR: begin
                flags[FLAG_P] = par_w;
                flags[FLAG_C] = carry;
            end
            default: known = 1'b0;
        endcase
        if (known) begin
            flags[FLAG_S] = res[MSB];
            flags[FLAG_Z] = (res == '0);
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: one operation at a time, shifts/rotates one bit per cycle.
// Define ALU_CARRY_IN_EN to add the cin port and the ADC/SBC opcodes.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
`ifdef ALU_CARRY_IN_EN
    input  logic             cin,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [7:0]       flags
);

    // Handshake: an operation is accepted on a rising edge where in_valid and
    // in_ready are both high; a result is consumed on a rising edge where
    // out_valid and out_ready are both high. result/flags/out_valid hold until then.

    st_e                state_q;
    st_e                state_d;
    logic [4:0]         op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   wrk_q;
    logic [SHAMT_W-1:0] cnt_q;
    logic [WIDTH-1:0]   result_q;
    logic [7:0]         flags_q;
`ifdef ALU_CARRY_IN_EN
    logic               cin_q;
`endif

    logic [SHAMT_W-1:0] amt;
    logic [WIDTH:0]     sum_w;
    logic [WIDTH-1:0]   opb_w;
    logic [WIDTH-1:0]   calc_res;
    logic               calc_c;
    logic [WIDTH-1:0]   out_res;
    logic [WIDTH-1:0]   step_w;
    logic               step_c;
    logic [WIDTH-1:0]   fg_res;
    logic               fg_c;
    logic [7:0]         flag_w;

    assign amt       = b_q[SHAMT_W-1:0];
    assign in_ready  = (state_q == ST_IDLE) && !rst;
    assign out_valid = (state_q == ST_HOLD);
    assign result    = result_q;
    assign flags     = flags_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (in_valid) state_d = ST_EXEC;
            ST_EXEC:  state_d = (is_shift(op_q) && (amt != '0)) ? ST_SHIFT : ST_HOLD;
            ST_SHIFT: if (cnt_q == SHAMT_W'(1)) state_d = ST_HOLD;
            ST_HOLD:  if (out_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Single-cycle datapath; CP reports a but flags the difference.
    always_comb begin
        opb_w = b_q;
        sum_w = '0;
        case (op_q)
            OP_ADD:        sum_w = {1'b0, a_q} + {1'b0, b_q};
            OP_SUB, OP_CP: sum_w = {1'b0, a_q} - {1'b0, b_q};
            OP_INC: begin
                opb_w = WIDTH'(1);
                sum_w = {1'b0, a_q} + (WIDTH+1)'(1);
            end
            OP_DEC: begin
                opb_w = WIDTH'(1);
                sum_w = {1'b0, a_q} - (WIDTH+1)'(1);
            end
`ifdef ALU_CARRY_IN_EN
            OP_ADC: sum_w = {1'b0, a_q} + {1'b0, b_q} + (WIDTH+1)'(cin_q);
            OP_SBC: sum_w = {1'b0, a_q} - {1'b0, b_q} - (WIDTH+1)'(cin_q);
`endif
            default: sum_w = '0;
        endcase
        calc_res = sum_w[WIDTH-1:0];
        calc_c   = sum_w[WIDTH];
        case (op_q)
            OP_AND: calc_res = a_q & b_q;
            OP_OR:  calc_res = a_q | b_q;
            OP_XOR: calc_res = a_q ^ b_q;
            OP_SLL, OP_SRL, OP_SLA, OP_SRA, OP_ROL, OP_ROR: calc_res = a_q;
            default: ;
        endcase
        out_res = (op_q == OP_CP) ? a_q : calc_res;
    end

    always_comb begin
        step_w = wrk_q;
        step_c = 1'b0;
        case (op_q)
            OP_SLL, OP_SLA: begin
                step_w = {wrk_q[WIDTH-2:0], 1'b0};
                step_c = wrk_q[WIDTH-1];
            end
            OP_SRL: begin
                step_w = {1'b0, wrk_q[WIDTH-1:1]};
                step_c = wrk_q[0];
            end
            OP_SRA: begin
                step_w = {wrk_q[WIDTH-1], wrk_q[WIDTH-1:1]};
                step_c = wrk_q[0];
            end
            OP_ROL: begin
                step_w = {wrk_q[WIDTH-2:0], wrk_q[WIDTH-1]};
                step_c = wrk_q[WIDTH-1];
            end
            OP_ROR: begin
                step_w = {wrk_q[0], wrk_q[WIDTH-1:1]};
                step_c = wrk_q[0];
            end
            default: ;
        endcase
    end

    assign fg_res = (state_q == ST_SHIFT) ? step_w : calc_res;
    assign fg_c   = (state_q == ST_SHIFT) ? step_c : calc_c;

    alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
        .op     (op_q),
        .a      (a_q),
        .b      (opb_w),
        .res    (fg_res),
        .carry  (fg_c),
        .c_prev (flags_q[FLAG_C]),
        .flags  (flag_w)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            wrk_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            flags_q  <= '0;
`ifdef ALU_CARRY_IN_EN
            cin_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        op_q  <= opcode;
                        a_q   <= a;
                        b_q   <= b;
`ifdef ALU_CARRY_IN_EN
                        cin_q <= cin;
`endif
                    end
                end
                ST_EXEC: begin
                    if (state_d == ST_SHIFT) begin
                        wrk_q <= a_q;
                        cnt_q <= amt;
                    end else begin
                        result_q <= out_res;
                        flags_q  <= flag_w;
                    end
                end
                ST_SHIFT: begin
                    wrk_q <= step_w;
                    cnt_q <= cnt_q - SHAMT_W'(1);
                    if (state_d == ST_HOLD) begin
                        result_q <= step_w;
                        flags_q  <= flag_w;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: vector table plus hand-written hold and
// mid-shift reset sequences.
module tb_alu_seq;
    import alu_pkg::*;

    typedef struct {
        logic [4:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] res;
        logic [7:0] flg;
        int         lat;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       cin = 1'b0;
    logic [4:0] opcode = '0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] result;
    logic [7:0] flags;

    int   n_checks = 0;
    int   n_fail = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef ALU_CARRY_IN_EN
        .cin       (cin),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [4:0] op, input logic [7:0] va, input logic [7:0] vb,
                                input logic vc, input logic [7:0] r, input logic [7:0] f, input int l);
        vec_t v;
        v.op = op; v.a = va; v.b = vb; v.cin = vc; v.res = r; v.flg = f; v.lat = l;
        return v;
    endfunction

    // Accept one operation, then count rising edges until out_valid (bounded).
    task automatic issue(input logic [4:0] op, input logic [7:0] va, input logic [7:0] vb,
                         input logic vc, output int lat);
        @(negedge clk);
        check("in_ready_idle", in_ready, 1);
        opcode = op; a = va; b = vb; cin = vc; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = ~va; b = ~vb; cin = ~vc;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("out_valid_seen", out_valid, 1);
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int seen;

        vecs.push_back(mk(OP_ADD, 8'h7F, 8'h01, 1'b0, 8'h80, 8'h94, 1));
        vecs.push_back(mk(OP_SUB, 8'h00, 8'h01, 1'b0, 8'hFF, 8'h93, 1));
        vecs.push_back(mk(OP_INC, 8'hFF, 8'h00, 1'b0, 8'h00, 8'h51, 1));
        vecs.push_back(mk(OP_DEC, 8'h00, 8'h00, 1'b0, 8'hFF, 8'h93, 1));
        vecs.push_back(mk(OP_AND, 8'hF0, 8'h3C, 1'b0, 8'h30, 8'h14, 1));
        vecs.push_back(mk(OP_OR,  8'h00, 8'h00, 1'b0, 8'h00, 8'h44, 1));
        vecs.push_back(mk(OP_XOR, 8'hFF, 8'h01, 1'b0, 8'hFE, 8'h80, 1));
        vecs.push_back(mk(OP_CP,  8'h10, 8'h20, 1'b0, 8'h10, 8'h83, 1));
        vecs.push_back(mk(OP_ROL, 8'h81, 8'h03, 1'b0, 8'h0C, 8'h04, 4));
        vecs.push_back(mk(OP_ROL, 8'h81, 8'h08, 1'b0, 8'h81, 8'h84, 1));
        vecs.push_back(mk(OP_SRL, 8'h01, 8'h01, 1'b0, 8'h00, 8'h45, 2));
        vecs.push_back(mk(OP_SRA, 8'h80, 8'h07, 1'b0, 8'hFF, 8'h84, 8));
        vecs.push_back(mk(OP_SLL, 8'h55, 8'h01, 1'b0, 8'hAA, 8'h84, 2));
        vecs.push_back(mk(OP_SLA, 8'hC0, 8'h02, 1'b0, 8'h00, 8'h45, 3));
        vecs.push_back(mk(OP_ROR, 8'h01, 8'h01, 1'b0, 8'h80, 8'h81, 2));
        vecs.push_back(mk(5'd20,  8'h05, 8'h03, 1'b0, 8'h00, 8'h00, 1));
        vecs.push_back(mk(OP_ADD, 8'hFF, 8'h01, 1'b0, 8'h00, 8'h51, 1));
        vecs.push_back(mk(OP_SUB, 8'h80, 8'h01, 1'b0, 8'h7F, 8'h16, 1));
`ifdef ALU_CARRY_IN_EN
        vecs.push_back(mk(OP_ADC, 8'hFF, 8'h00, 1'b1, 8'h00, 8'h51, 1));
        vecs.push_back(mk(OP_SBC, 8'h00, 8'h00, 1'b1, 8'hFF, 8'h93, 1));
`else
        vecs.push_back(mk(OP_ADC, 8'hFF, 8'h00, 1'b1, 8'h00, 8'h00, 1));
        vecs.push_back(mk(OP_SBC, 8'h00, 8'h00, 1'b1, 8'h00, 8'h00, 1));
`endif

        // Reset state while rst is held high.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_flags", flags, 0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin, lat);
            check($sformatf("v%0d_result", i), result, vecs[i].res);
            check($sformatf("v%0d_flags", i), flags, vecs[i].flg);
            check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            release_result();
        end

        // Consumer stalls for 5 cycles while a new request is offered.
        issue(OP_ADD, 8'h01, 8'h02, 1'b0, lat);
        check("hold_first_result", result, 8'h03);
        opcode = OP_SUB; a = 8'h55; b = 8'h11; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check($sformatf("hold%0d_result", i), result, 8'h03);
            check($sformatf("hold%0d_flags", i), flags, 8'h00);
            check($sformatf("hold%0d_out_valid", i), out_valid, 1);
            check($sformatf("hold%0d_in_ready", i), in_ready, 0);
        end
        in_valid = 1'b0;
        release_result();
        check("post_hold_in_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        #1;
        check("post_hold_no_accept", out_valid, 0);

        // Reset pulsed on the third SHIFT cycle of SRA by 7.
        @(negedge clk);
        check("sra_in_ready", in_ready, 1);
        opcode = OP_SRA; a = 8'h80; b = 8'h07; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_rst_in_ready", in_ready, 0);
        check("abort_rst_out_valid", out_valid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_flags", flags, 8'h00);
        check("abort_result", result, 8'h00);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("abort_no_out_valid", seen, 0);

        // Carry was cleared by reset, so INC must report C=0.
        issue(OP_INC, 8'h00, 8'h00, 1'b0, lat);
        check("inc_after_rst_result", result, 8'h01);
        check("inc_after_rst_flags", flags, 8'h00);
        check("inc_after_rst_latency", lat, 1);
        release_result();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
